// File: rtl/seq_multiplier.sv
// Sequential shift-and-add unsigned multiplier feeding the HiLo stage.
// One multiplier bit is retired per clock, LSB first. The product and the
// opcode are published together with a one-cycle done pulse. The opcode is
// only carried through; MULTU and MADDU behave identically here.
module seq_multiplier #(
  parameter logic [5:0] MULTU = 6'd1,
  parameter logic [5:0] MADDU = 6'd28,
  parameter int         WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [5:0]           op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   MulAns,
  output logic [5:0]           opOut,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, next_state;

  // Multiplicand widened to the product width so it can be shifted left
  // WIDTH-1 times without losing bits.
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mplier;
  logic [5:0]         op_latched;
  logic [5:0]         count;
  logic               accept;
  logic               last_bit;

  // A start is honoured only while idle and only for a multiply opcode.
  assign accept   = (state == IDLE) && start && ((op == MULTU) || (op == MADDU));
  // The count tracks how many bits have been retired before this edge, so
  // the WIDTH-th CALC edge is the one that sees WIDTH-1.
  assign last_bit = (count == 6'(WIDTH - 1));
  assign addend   = mplier[0] ? mcand : '0;
  assign acc_next = acc + addend;

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state selection: accept, run for WIDTH edges, one DONE cycle.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (accept) next_state = CALC;
      CALC:    if (last_bit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs decoded purely from the current state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE:    busy = 1'b0;
      CALC:    busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Datapath: latch operands on accept, shift-and-add in CALC, and publish
  // the final sum and the latched opcode on the last CALC edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      count      <= '0;
      op_latched <= '0;
      MulAns     <= '0;
      opOut      <= '0;
    end else if (accept) begin
      mcand      <= {{WIDTH{1'b0}}, a};
      mplier     <= b;
      op_latched <= op;
      acc        <= '0;
      count      <= '0;
    end else if (state == CALC) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + 6'd1;
      if (last_bit) begin
        MulAns <= acc_next;
        opOut  <= op_latched;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Testbench for seq_multiplier: a cycle-count reference model checked every
// cycle, plus directed scenarios with hand-computed results.
module tb_seq_multiplier;

  localparam int WIDTH = 32;

  logic              clk;
  logic              rst;
  logic              start;
  logic [5:0]        op;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [63:0]       MulAns;
  logic [5:0]        opOut;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  int cycle_count = 0;
  int busy_count = 0;
  int done_cycles[$];
  logic [63:0] done_vals[$];

  // Reference model state: cycles of busy remaining, pending product/op,
  // and the values the outputs must currently show.
  int          m_left = 0;
  logic [63:0] m_prod = '0;
  logic [5:0]  m_op = '0;
  logic [63:0] m_mulans = '0;
  logic [5:0]  m_opout = '0;

  seq_multiplier #(
    .MULTU(6'd1),
    .MADDU(6'd28),
    .WIDTH(WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .a(a),
    .b(b),
    .MulAns(MulAns),
    .opOut(opOut),
    .busy(busy),
    .done(done)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for done-pulse spacing.
  always @(posedge clk) begin
    cycle_count <= cycle_count + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d",
               name, actual, expected, cycle_count);
    end
  endtask

  // Reference model: an accepted multiply keeps the unit busy for WIDTH+1
  // cycles; the product a*b appears with done in the last of them.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left   <= 0;
      m_prod   <= '0;
      m_op     <= '0;
      m_mulans <= '0;
      m_opout  <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_mulans <= m_prod;
        m_opout  <= m_op;
      end
    end else if (start && (op == 6'd1 || op == 6'd28)) begin
      m_left <= WIDTH + 1;
      m_prod <= 64'(a) * 64'(b);
      m_op   <= op;
    end
  end

  // Compare DUT against the model every cycle, mid-period.
  always @(negedge clk) begin
    checkOutput("busy", {63'b0, busy}, {63'b0, m_left != 0});
    checkOutput("done", {63'b0, done}, {63'b0, m_left == 1});
    checkOutput("MulAns", MulAns, m_mulans);
    checkOutput("opOut", {58'b0, opOut}, {58'b0, m_opout});
  end

  // Activity monitor: busy cycles, done pulse times and products.
  always @(negedge clk) begin
    if (busy) busy_count <= busy_count + 1;
    if (done) begin
      done_cycles.push_back(cycle_count);
      done_vals.push_back(MulAns);
    end
  end

  task automatic clearMonitor();
    busy_count = 0;
    done_cycles.delete();
    done_vals.delete();
  endtask

  // Present a one-cycle start; returns just after the sampling edge.
  task automatic applyStimulus(input logic [5:0] op_v, input logic [WIDTH-1:0] a_v,
                               input logic [WIDTH-1:0] b_v);
    @(posedge clk);
    #2;
    start = 1'b1;
    op    = op_v;
    a     = a_v;
    b     = b_v;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  // Wait for a done pulse with a bounded cycle budget.
  task automatic waitDone();
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op    = 6'd0;
    a     = '0;
    b     = '0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_MulAns", MulAns, 64'd0);
    checkOutput("reset_opOut", {58'b0, opOut}, 64'd0);
    checkOutput("reset_busy", {63'b0, busy}, 64'd0);
    checkOutput("reset_done", {63'b0, done}, 64'd0);
    @(posedge clk);
    #2 rst = 1'b1;

    $display("[TB] basic multiply 3*5");
    clearMonitor();
    applyStimulus(6'd1, 32'd3, 32'd5);
    waitDone();
    repeat (3) @(negedge clk);
    checkOutput("basic_MulAns", MulAns, 64'd15);
    checkOutput("basic_opOut", {58'b0, opOut}, 64'd1);
    checkOutput("basic_busy_cycles", 64'(busy_count), 64'd33);
    checkOutput("basic_done_count", 64'(done_cycles.size()), 64'd1);

    $display("[TB] maximum operands");
    clearMonitor();
    applyStimulus(6'd28, 32'hFFFFFFFF, 32'hFFFFFFFF);
    waitDone();
    repeat (3) @(negedge clk);
    checkOutput("max_MulAns", MulAns, 64'hFFFFFFFE_00000001);
    checkOutput("max_opOut", {58'b0, opOut}, 64'd28);
    checkOutput("max_done_count", 64'(done_cycles.size()), 64'd1);

    $display("[TB] illegal op then zero operand");
    clearMonitor();
    applyStimulus(6'd0, 32'd4, 32'd4);
    repeat (5) @(negedge clk);
    checkOutput("illegal_busy_cycles", 64'(busy_count), 64'd0);
    checkOutput("illegal_done_count", 64'(done_cycles.size()), 64'd0);
    checkOutput("illegal_MulAns_held", MulAns, 64'hFFFFFFFE_00000001);
    clearMonitor();
    applyStimulus(6'd1, 32'd0, 32'h12345678);
    waitDone();
    repeat (3) @(negedge clk);
    checkOutput("zero_MulAns", MulAns, 64'd0);
    checkOutput("zero_busy_cycles", 64'(busy_count), 64'd33);

    $display("[TB] start while busy");
    clearMonitor();
    applyStimulus(6'd1, 32'd7, 32'd6);
    repeat (9) @(posedge clk);
    #2;
    start = 1'b1;
    op    = 6'd1;
    a     = 32'd9;
    b     = 32'd9;
    @(posedge clk);
    #2;
    start = 1'b0;
    op    = 6'd28;
    a     = 32'hDEADBEEF;
    b     = 32'h0BADF00D;
    waitDone();
    repeat (40) @(negedge clk);
    checkOutput("busy_MulAns", MulAns, 64'd42);
    checkOutput("busy_opOut", {58'b0, opOut}, 64'd1);
    checkOutput("busy_done_count", 64'(done_cycles.size()), 64'd1);

    $display("[TB] reset mid-operation");
    clearMonitor();
    applyStimulus(6'd1, 32'd5, 32'd5);
    repeat (15) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_busy", {63'b0, busy}, 64'd0);
    checkOutput("abort_MulAns", MulAns, 64'd0);
    checkOutput("abort_done", {63'b0, done}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("abort_done_count", 64'(done_cycles.size()), 64'd0);
    applyStimulus(6'd1, 32'd2, 32'd2);
    waitDone();
    repeat (3) @(negedge clk);
    checkOutput("after_reset_MulAns", MulAns, 64'd4);

    $display("[TB] back-to-back");
    clearMonitor();
    applyStimulus(6'd1, 32'd10, 32'd10);
    waitDone();
    @(posedge clk);
    #2;
    start = 1'b1;
    op    = 6'd1;
    a     = 32'd11;
    b     = 32'd11;
    @(posedge clk);
    #2 start = 1'b0;
    waitDone();
    repeat (3) @(negedge clk);
    checkOutput("b2b_done_count", 64'(done_cycles.size()), 64'd2);
    if (done_cycles.size() == 2) begin
      checkOutput("b2b_first", done_vals[0], 64'd100);
      checkOutput("b2b_second", done_vals[1], 64'd121);
      checkOutput("b2b_spacing", 64'(done_cycles[1] - done_cycles[0]), 64'd34);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter MULTU, default 6'd1, opcode for unsigned multiply.
REQ-002 SHALL have parameter MADDU, default 6'd28, opcode for unsigned multiply-accumulate.
REQ-003 SHALL have parameter WIDTH, default 32, operand width.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port start  input  1  request to begin a multiply; sampled on the rising edge.
REQ-007 SHALL have port op  input  6  opcode presented with start.
REQ-008 SHALL have port a  input  WIDTH  multiplicand, unsigned.
REQ-009 SHALL have port b  input  WIDTH  multiplier, unsigned.
REQ-010 SHALL have port MulAns  output  2*WIDTH  product, driven to the HiLo stage.
REQ-011 SHALL have port opOut  output  6  opcode latched at accept, driven to the HiLo op input.
REQ-012 SHALL have port busy  output  1  high while an operation is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse; MulAns and opOut are valid.

Function
REQ-014 SHALL implement three states: IDLE, CALC and DONE.
REQ-015 SHALL accept start only in IDLE, and only when op equals MULTU or MADDU.
REQ-016 SHALL ignore start with any other op: no state change, and outputs hold.
REQ-017 On accept (edge N), SHALL latch a, b and op, clear the accumulator and the 6-bit iteration counter, and enter CALC.
REQ-018 Each CALC edge SHALL retire one multiplier bit, LSB first, by shift-and-add.
REQ-019 The shift-and-add SHALL use an accumulator of width 2*WIDTH, so no overflow is possible.
REQ-020 After the WIDTH-th CALC edge (edge N+WIDTH), SHALL load MulAns with the full product, load opOut, and enter DONE.
REQ-021 SHALL assert done only in DONE, for exactly one cycle, between edges N+WIDTH and N+WIDTH+1.
REQ-022 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-023 busy SHALL be high in CALC and DONE, and low in IDLE.
REQ-024 start while busy SHALL be ignored; the in-flight operation SHALL be unaffected.
REQ-025 Operand changes on a, b or op after accept SHALL NOT affect the result.
REQ-026 MulAns and opOut SHALL hold their values from the end of DONE until the next DONE; they SHALL NOT change during CALC.
REQ-027 Back-to-back operation: a start in the IDLE cycle immediately after DONE SHALL be accepted, giving a throughput of one operation per WIDTH+2 cycles.
REQ-028 Operation SHALL be identical for MULTU and MADDU; accumulation is the HiLo stage's job. op is only passed through on opOut.
REQ-029 Zero operands SHALL still take the full WIDTH cycles; there SHALL be no early termination.

Reset
REQ-030 rst low SHALL immediately, without waiting for clk, force: state IDLE, counter 0, accumulator 0, MulAns 0, opOut 0, busy 0, done 0.
REQ-031 Reset asserted mid-CALC or in DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-032 After rst returns high, the first rising edge with a valid start SHALL be accepted normally.

Verification
REQ-033 Basic multiply: op=1, a=3, b=5, start for 1 cycle -> done pulses 32 cycles after accept, MulAns=64'd15, opOut=1, busy high for 33 cycles.
REQ-034 Maximum operands: op=28, a=b=32'hFFFFFFFF -> MulAns=64'hFFFFFFFE_00000001, opOut=28, single done pulse.
REQ-035 Illegal op and zero operand: start with op=0 -> no busy and no done. Then op=1, a=0, b=32'h12345678 -> MulAns=0 after the full 32-cycle latency.
REQ-036 Busy protection: accept a=7, b=6; at cycle 10 assert start with a=9, b=9, and change a and b -> MulAns=42 only, one done pulse, second start lost.
REQ-037 Reset mid-operation: rst low at cycle 15 of CALC -> MulAns=0, busy=0, done never pulses. A new op=1, a=2, b=2 after release -> MulAns=4.
REQ-038 Back-to-back: accept a=10, b=10, then start again in the IDLE cycle after done with a=11, b=11 -> MulAns=100, then 121, with done pulses 34 cycles apart.
